// File: rtl/truth_table_checker.sv
// Exhaustive truth-table sweep of a small combinational gate: drives every input vector,
// samples the 1-bit response after a settle delay, and reports error count and first failure.
module truth_table_checker #(
   parameter int unsigned N_IN = 2,
   parameter logic [(2**N_IN)-1:0] EXPECTED = 4'b1000,
   parameter int unsigned SETTLE = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic [N_IN-1:0] dut_in,
   input  logic            dut_out,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic [N_IN-1:0] first_fail_vec,
   output logic            first_fail_valid
);

   // Counter only ever holds values up to SETTLE-1.
   localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE - 1);
   localparam logic [CntW-1:0] CntOne = CntW'(1);
   localparam logic [N_IN-1:0] VecOne = N_IN'(1);
   localparam logic [N_IN-1:0] VecLast = {N_IN{1'b1}};
   localparam logic [N_IN:0] ErrOne = (N_IN + 1)'(1);

   typedef enum logic [1:0] {StIdle, StWait, StSample, StDone} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
   logic [N_IN-1:0]   dut_in_q, dut_in_d;
   logic [N_IN:0]     err_q, err_d;
   logic [N_IN-1:0]   ff_vec_q, ff_vec_d;
   logic              ff_valid_q, ff_valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              mismatch;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         wait_cnt_q <= '0;
         dut_in_q   <= '0;
         err_q      <= '0;
         ff_vec_q   <= '0;
         ff_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         dut_in_q   <= dut_in_d;
         err_q      <= err_d;
         ff_vec_q   <= ff_vec_d;
         ff_valid_q <= ff_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      dut_in_d   = dut_in_q;
      err_d      = err_q;
      ff_vec_d   = ff_vec_q;
      ff_valid_d = ff_valid_q;
      busy_d     = busy_q;
      done_d     = done_q;
      pass_d     = pass_q;
      mismatch   = 1'b0;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d    = StWait;
               dut_in_d   = '0;
               wait_cnt_d = CntLoad;
               err_d      = '0;
               ff_vec_d   = '0;
               ff_valid_d = 1'b0;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               pass_d     = 1'b0;
            end
         end
         StWait: begin
            if (wait_cnt_q == '0) begin
               state_d = StSample;
            end else begin
               wait_cnt_d = wait_cnt_q - CntOne;
            end
         end
         StSample: begin
            // dut_out is only looked at here, so X elsewhere is harmless.
            mismatch = (dut_out != EXPECTED[dut_in_q]);
            if (mismatch) begin
               err_d = err_q + ErrOne;
               if (!ff_valid_q) begin
                  ff_vec_d   = dut_in_q;
                  ff_valid_d = 1'b1;
               end
            end
            if (dut_in_q == VecLast) begin
               state_d = StDone;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_d == '0);
            end else begin
               state_d    = StWait;
               dut_in_d   = dut_in_q + VecOne;
               wait_cnt_d = CntLoad;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign dut_in           = dut_in_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign err_count        = err_q;
   assign first_fail_vec   = ff_vec_q;
   assign first_fail_valid = ff_valid_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: a default 2-input instance and a 3-input/SETTLE=3 instance,
// each driving a table-defined gate, checked against a vector-walk reference model.
module tb_truth_table_checker;

   logic clk = 1'b0;
   logic rst;
   logic start2, start3;
   logic [3:0] tt2;
   logic [7:0] tt3;

   logic [1:0] dut_in2;
   logic       dut_out2, busy2, done2, pass2, ffok2;
   logic [2:0] err2;
   logic [1:0] ffv2;

   logic [2:0] dut_in3;
   logic       dut_out3, busy3, done3, pass3, ffok3;
   logic [3:0] err3;
   logic [2:0] ffv3;

   int errors = 0;
   int checks = 0;
   int sel = 0;

   logic [31:0] o_dut_in, o_err, o_ffv;
   logic        o_busy, o_done, o_pass, o_ffok;

   always #5 clk = ~clk;

   // The gates under test are pure lookups of the bench-chosen tables.
   assign dut_out2 = tt2[dut_in2];
   assign dut_out3 = tt3[dut_in3];

   truth_table_checker u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .dut_in(dut_in2), .dut_out(dut_out2),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
      .first_fail_vec(ffv2), .first_fail_valid(ffok2)
   );

   truth_table_checker #(.N_IN(3), .EXPECTED(8'h80), .SETTLE(3)) u_dut3 (
      .clk(clk), .rst(rst), .start(start3), .dut_in(dut_in3), .dut_out(dut_out3),
      .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
      .first_fail_vec(ffv3), .first_fail_valid(ffok3)
   );

   always_comb begin
      o_dut_in = sel != 0 ? {29'd0, dut_in3} : {30'd0, dut_in2};
      o_err    = sel != 0 ? {28'd0, err3} : {29'd0, err2};
      o_ffv    = sel != 0 ? {29'd0, ffv3} : {30'd0, ffv2};
      o_busy   = sel != 0 ? busy3 : busy2;
      o_done   = sel != 0 ? done3 : done2;
      o_pass   = sel != 0 ? pass3 : pass2;
      o_ffok   = sel != 0 ? ffok3 : ffok2;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic set_start(input logic v);
      if (sel != 0) start3 = v;
      else start2 = v;
   endtask

   // Full sweep; repulse_at >= 0 pulses start during that cycle of the sweep (must be ignored).
   task automatic sweep(input int sel_i, input logic [7:0] tbl, input int repulse_at);
      int n, settle, nvec, len, errs, first;
      logic [7:0] exp_tt;
      sel    = sel_i;
      n      = sel_i != 0 ? 3 : 2;
      settle = sel_i != 0 ? 3 : 1;
      exp_tt = sel_i != 0 ? 8'h80 : 8'h08;
      nvec   = 1 << n;
      len    = nvec * (settle + 1);
      errs   = 0;
      first  = -1;
      for (int v = 0; v < nvec; v++) begin
         if (tbl[v] != exp_tt[v]) begin
            errs++;
            if (first < 0) first = v;
         end
      end
      if (sel_i != 0) tt3 = tbl;
      else tt2 = tbl[3:0];

      @(negedge clk);
      set_start(1'b1);
      @(negedge clk);
      set_start(1'b0);
      check("start_err", o_err, 0);
      check("start_pass", {31'd0, o_pass}, 0);
      check("start_ffok", {31'd0, o_ffok}, 0);
      check("start_ffv", o_ffv, 0);
      for (int k = 0; k < len; k++) begin
         if (k > 0) @(negedge clk);
         set_start(k == repulse_at);
         check("busy", {31'd0, o_busy}, 1);
         check("done_early", {31'd0, o_done}, 0);
         check("dut_in", o_dut_in, k / (settle + 1));
      end
      @(negedge clk);
      set_start(1'b0);
      check("done", {31'd0, o_done}, 1);
      check("busy_end", {31'd0, o_busy}, 0);
      check("pass", {31'd0, o_pass}, errs == 0 ? 1 : 0);
      check("err_count", o_err, errs);
      check("ff_valid", {31'd0, o_ffok}, errs != 0 ? 1 : 0);
      check("ff_vec", o_ffv, first < 0 ? 0 : first);
      check("dut_in_last", o_dut_in, nvec - 1);
      repeat (2) @(negedge clk);
      check("done_hold", {31'd0, o_done}, 1);
      check("err_hold", o_err, errs);
   endtask

   initial begin
      rst = 1'b1;
      start2 = 1'b0;
      start3 = 1'b0;
      tt2 = 4'h0;
      tt3 = 8'h00;
      #1;
      check("rst_busy", {30'd0, busy3, busy2}, 0);
      check("rst_done", {30'd0, done3, done2}, 0);
      check("rst_pass", {30'd0, pass3, pass2}, 0);
      check("rst_dut_in", {27'd0, dut_in3, dut_in2}, 0);
      check("rst_err", {25'd0, err3, err2}, 0);
      check("rst_ff", {25'd0, ffok3, ffv3, ffok2, ffv2}, 0);
      @(negedge clk);
      rst = 1'b0;

      sweep(0, 8'h08, -1);   // correct AND
      sweep(0, 8'h00, -1);   // stuck at 0
      sweep(0, 8'h0e, -1);   // OR in place of AND
      sweep(0, 8'h08, 2);    // restart request mid-sweep ignored
      sweep(0, 8'h08, -1);   // start from DONE clears results

      // Asynchronous reset between edges while dut_in == 2.
      sel = 0;
      tt2 = 4'he;
      @(negedge clk);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      repeat (4) @(negedge clk);
      check("pre_rst_dut_in", o_dut_in, 2);
      check("pre_rst_err", o_err, 1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_busy", {31'd0, o_busy}, 0);
      check("mid_rst_dut_in", o_dut_in, 0);
      check("mid_rst_err", o_err, 0);
      check("mid_rst_ffok", {31'd0, o_ffok}, 0);
      @(negedge clk);
      rst = 1'b0;
      sweep(0, 8'h00, -1);

      sweep(1, 8'h7f, -1);   // NAND3: every vector mismatches, no wrap
      sweep(1, 8'h80, -1);   // AND3

      for (int i = 0; i < 6; i++) begin
         sweep(0, 8'($urandom_range(0, 15)), int'($urandom_range(0, 7)) - 1);
         sweep(1, 8'($urandom_range(0, 255)), int'($urandom_range(0, 31)) - 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Synthesizable exhaustive stimulus-and-response block for small combinational gates such as g_and.
- On start, it drives every input vector 0..2^N_IN-1 into the device under test and samples the DUT's 1-bit output after a programmable settle time.
- It compares each sample against a parameterized truth table and reports pass/fail, the error count and the first failing vector.
- Sits beside the gate under test in on-chip self-check and board-bring-up designs.

Parameters:
- N_IN, 2: number of DUT inputs; legal range 1..8.
- EXPECTED, 4'b1000: expected truth table, width 2^N_IN; bit i is the expected DUT output for input vector i. The default is the 2-input AND.
- SETTLE, 1: number of cycles dut_in is held before the sampling cycle; legal range ≥1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  single-cycle request to begin a sweep; honoured only in IDLE or DONE
- dut_in  out  N_IN  registered stimulus to the DUT (bit N_IN-1 = MSB input)
- dut_out  in  1  DUT response; combinational from dut_in
- busy  out  1  high while a sweep is in progress
- done  out  1  high from sweep completion until the next accepted start or reset
- pass  out  1  valid when done=1; 1 when err_count==0
- err_count  out  N_IN+1  number of mismatching vectors in the last sweep
- first_fail_vec  out  N_IN  lowest input vector that mismatched
- first_fail_valid  out  1  1 when first_fail_vec holds a captured mismatch

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0, including dut_in, err_count and first_fail_vec.
- FSM states: IDLE, WAIT, SAMPLE, DONE.
- IDLE: start=1 at a clock edge moves to WAIT, with these updates in the same edge:
  - dut_in<=0; wait counter<=SETTLE-1
  - err_count<=0; first_fail_valid<=0; first_fail_vec<=0
  - done<=0; pass<=0; busy<=1
- WAIT: decrement the wait counter each cycle; when it reads 0, go to SAMPLE. dut_in is therefore stable for exactly SETTLE cycles before SAMPLE.
- SAMPLE: one cycle; at its closing edge compare dut_out with EXPECTED[dut_in].
  - On mismatch: err_count+1.
  - If first_fail_valid==0 on that mismatch: first_fail_vec<=dut_in and first_fail_valid<=1.
  - If dut_in == 2^N_IN-1: go to DONE with busy<=0, done<=1, and pass<=1 only if the final err_count (including this sample) is 0.
  - Otherwise: dut_in<=dut_in+1, reload the wait counter, go to WAIT.
- Latency: each vector occupies SETTLE+1 cycles. done rises at edge 2^N_IN·(SETTLE+1), counting the start edge as edge 0.
- DONE: results are held stable. start=1 restarts exactly as from IDLE, clearing all results in the same edge. dut_in holds its last vector.
- start while busy=1 is ignored; there is no queueing.
- err_count never wraps: its width N_IN+1 holds the maximum value 2^N_IN.
- dut_out is sampled only in SAMPLE; its value in other states is don't-care, X included.
- Reset mid-sweep: all outputs return to reset values immediately, without waiting for a clock. The partial sweep is discarded, and the next start begins from vector 0.

Test Plan:
1. Correct g_and DUT, defaults: pulse start → dut_in = 0,0,1,1,2,2,3,3 (2 cycles each); done=1 at edge 8; pass=1, err_count=0, first_fail_valid=0.
2. DUT output stuck at 0, defaults → done at edge 8; pass=0, err_count=1, first_fail_vec=3, first_fail_valid=1.
3. OR gate in place of AND, defaults → err_count=2, first_fail_vec=1, pass=0.
4. start re-pulsed at cycle 3 of a sweep → ignored, done still at edge 8. A second start in DONE clears done, pass and err_count next edge, and dut_in returns to 0.
5. rst asserted while dut_in=2, between clock edges → busy, dut_in and err_count go to 0 before the next edge. After release plus start, the sweep restarts at vector 0.
6. N_IN=3, SETTLE=3, EXPECTED=8'h80, DUT = NAND3 → every vector mismatches: err_count=8 (no wrap), first_fail_vec=0; done at edge 32.
